// File: rtl/fifo_pkg.sv
// Shared geometry constants and pointer helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  // One bit wider than the storage index so full and empty can be told apart.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_PTR_W = ptrWidth(DEFAULT_DEPTH);

  typedef logic [DEFAULT_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [WIDTH-1:0]  i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [WIDTH-1:0]  o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdData;

  // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, accept logic and status flags around fifo_mem.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_write,
  input  logic             io_read,
  input  logic [WIDTH-1:0] io_din,
  output logic [WIDTH-1:0] io_dout,
  output logic             io_full,
  output logic             io_empty
);

  localparam int PTR_W  = ptrWidth(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic             w_wrAccept;
  logic             w_rdAccept;

  // Both requests are qualified against the flags as they stand before the edge.
  assign w_wrAccept = io_write && !io_full;
  assign w_rdAccept = io_read && !io_empty;

  assign io_empty = (r_wp == r_rp);
  assign io_full  = (r_wp[PTR_W-1] != r_rp[PTR_W-1]) &&
                    (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wrAccept) begin
        r_wp <= r_wp + PTR_W'(1);
      end
      if (w_rdAccept) begin
        r_rp <= r_rp + PTR_W'(1);
      end
    end
  end

  fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .i_wrEn   (w_wrAccept),
    .i_wrAddr (r_wp[ADDR_W-1:0]),
    .i_wrData (io_din),
    .i_rdEn   (w_rdAccept),
    .i_rdAddr (r_rp[ADDR_W-1:0]),
    .o_rdData (io_dout)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with hand-computed expectations.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic       io_full;
  logic       io_empty;

  int checkCount;
  int errorCount;

  sync_fifo #(
    .DEPTH (16),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_write (io_write),
    .io_read  (io_read),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .io_full  (io_full),
    .io_empty (io_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests, then settle 1 time unit past the edge for sampling.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] din);
    io_write = wr;
    io_read  = rd;
    io_din   = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset    = 1'b0;
    io_write = 1'b0;
    io_read  = 1'b0;
    io_din   = 8'h00;

    #3;
    checkOutput("rst_empty", 32'(io_empty), 32'd1);
    checkOutput("rst_full", 32'(io_full), 32'd0);
    checkOutput("rst_dout", 32'(io_dout), 32'h00);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      checkOutput("fill_empty", 32'(io_empty), 32'd0);
      checkOutput("fill_full", 32'(io_full), (i == 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 8'hAA);
    checkOutput("overflow_full", 32'(io_full), 32'd1);

    // Drain, expecting 0x00..0x0F (0xAA must never appear)
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("drain_dout", 32'(io_dout), 32'(i));
      checkOutput("drain_empty", 32'(io_empty), (i == 15) ? 32'd1 : 32'd0);
      checkOutput("drain_full", 32'(io_full), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("underflow_dout", 32'(io_dout), 32'h0F);
    checkOutput("underflow_empty", 32'(io_empty), 32'd1);

    // Wrap-around: write 10, read 10, write 16, read 16
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("wrap_a_dout", 32'(io_dout), 32'(8'h20 + i));
    end
    checkOutput("wrap_a_empty", 32'(io_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
      checkOutput("wrap_full", 32'(io_full), (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("wrap_b_dout", 32'(io_dout), 32'(8'h40 + i));
    end
    checkOutput("wrap_b_empty", 32'(io_empty), 32'd1);

    // Simultaneous read+write while empty: only the write lands
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("simE_dout", 32'(io_dout), 32'h4F);
    checkOutput("simE_empty", 32'(io_empty), 32'd0);
    for (int i = 1; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h77 + i));

    // 8 stored (0x77..0x7E); 20 cycles of concurrent traffic
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h80 + k));
      checkOutput("sim_dout", 32'(io_dout), (k < 8) ? 32'(8'h77 + k) : 32'(8'h80 + k - 8));
      checkOutput("sim_empty", 32'(io_empty), 32'd0);
      checkOutput("sim_full", 32'(io_full), 32'd0);
    end

    // 8 stored (0x8C..0x93); top up to full with 0xA0..0xA7
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'hA0 + i));
    checkOutput("topup_full", 32'(io_full), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'hEE);
    checkOutput("simF_dout", 32'(io_dout), 32'h8C);
    checkOutput("simF_full", 32'(io_full), 32'd0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("simF_drain", 32'(io_dout), (i < 7) ? 32'(8'h8D + i) : 32'(8'hA0 + i - 7));
    end
    checkOutput("simF_empty", 32'(io_empty), 32'd1);

    // Mid-stream reset with 5 words stored
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'(8'h51 + i));
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pre_rst_dout", 32'(io_dout), 32'h51);
    io_write = 1'b0;
    io_read  = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_empty", 32'(io_empty), 32'd1);
    checkOutput("midrst_full", 32'(io_full), 32'd0);
    checkOutput("midrst_dout", 32'(io_dout), 32'h00);
    #3 reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("postrst_rd_dout", 32'(io_dout), 32'h00);
    checkOutput("postrst_rd_empty", 32'(io_empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h3C);
    checkOutput("postrst_wr_empty", 32'(io_empty), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("postrst_dout", 32'(io_dout), 32'h3C);
    checkOutput("postrst_empty", 32'(io_empty), 32'd1);

    io_write = 1'b0;
    io_read  = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
